// File: rtl/mod_tx_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mod_tx_sequencer: byte-serial ASK/FSK transmit sequencer with per-bit     |
// | programmable phase-step rate and 4-state carrier phase.  Rev 1.0          |
// +--------------------------------------------------------------------------+
module mod_tx_sequencer #(
  parameter int DATA_W      = 8,
  parameter int DIV_W       = 6,
  parameter int CYC_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [DIV_W-1:0]  div_f0,
  input  logic [DIV_W-1:0]  div_f1,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              phase_tick,
  output logic              p,
  output logic              s,
  output logic              carrier_en,
  output logic              freq_sel,
  output logic              busy,
  output logic              done
);

  localparam int c_BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int c_CW = (CYC_PER_BIT > 1) ? $clog2(CYC_PER_BIT) : 1;
  localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(DATA_W - 1);
  localparam logic [c_CW-1:0] c_CYC_LAST = c_CW'(CYC_PER_BIT - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [DATA_W-1:0]  r_shift;
  logic               r_mode;
  logic [DIV_W-1:0]   r_div0;
  logic [DIV_W-1:0]   r_div1;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [1:0]         r_phase;
  logic [c_BW-1:0]    r_bit_cnt;
  logic [c_CW-1:0]    r_cyc_cnt;
  logic               r_done;

  logic               w_accept;
  logic               w_tick;
  logic               w_cyc_end;
  logic               w_bit_end;
  logic               w_word_end;
  logic [DATA_W-1:0]  w_shift_nx;
  logic               w_next_bit;
  logic [DIV_W-1:0]   w_reload;
  logic [DIV_W-1:0]   w_load;

  // Deff-1 with a zero divisor treated as one; bit value only matters in FSK.
  function automatic logic [DIV_W-1:0] f_deff_m1(input logic m, input logic b,
                                                 input logic [DIV_W-1:0] d0,
                                                 input logic [DIV_W-1:0] d1);
    logic [DIV_W-1:0] d;
    d = (m && b) ? d1 : d0;
    return (d == '0) ? '0 : d - DIV_W'(1);
  endfunction

  assign w_accept   = (r_state == S_IDLE) && in_valid;
  assign w_tick     = (r_state == S_SEND) && (r_div_cnt == '0);
  assign w_cyc_end  = w_tick && (r_phase == 2'b11);
  assign w_bit_end  = w_cyc_end && (r_cyc_cnt == c_CYC_LAST);
  assign w_word_end = w_bit_end && (r_bit_cnt == c_BIT_LAST);
  assign w_shift_nx = {1'b0, r_shift[DATA_W-1:1]};
  assign w_next_bit = w_bit_end ? r_shift[1] : r_shift[0];
  assign w_reload   = f_deff_m1(r_mode, w_next_bit, r_div0, r_div1);
  assign w_load     = f_deff_m1(mode, in_data[0], div_f0, div_f1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nx = S_SEND;
      S_SEND: if (w_word_end) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift   <= '0;
      r_mode    <= 1'b0;
      r_div0    <= '0;
      r_div1    <= '0;
      r_div_cnt <= '0;
      r_phase   <= 2'b00;
      r_bit_cnt <= '0;
      r_cyc_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_shift   <= in_data;
        r_mode    <= mode;
        r_div0    <= div_f0;
        r_div1    <= div_f1;
        r_div_cnt <= w_load;
        r_phase   <= 2'b00;
        r_bit_cnt <= '0;
        r_cyc_cnt <= '0;
      end else if (w_tick) begin
        r_phase   <= r_phase + 2'b01;
        r_div_cnt <= w_reload;
        if (w_bit_end) begin
          r_cyc_cnt <= '0;
          r_shift   <= w_shift_nx;
          r_bit_cnt <= w_word_end ? '0 : r_bit_cnt + 1'b1;
          r_done    <= w_word_end;
        end else if (w_cyc_end) begin
          r_cyc_cnt <= r_cyc_cnt + 1'b1;
        end
      end else if (r_state == S_SEND) begin
        r_div_cnt <= r_div_cnt - DIV_W'(1);
      end
    end
  end

  // Outputs decode registered state only, so an async reset clears them at once.
  assign in_ready   = (r_state == S_IDLE);
  assign busy       = (r_state == S_SEND);
  assign phase_tick = w_tick;
  assign p          = r_phase[0];
  assign s          = r_phase[1];
  assign carrier_en = busy && (r_mode || r_shift[0]);
  assign freq_sel   = busy && r_mode && r_shift[0];
  assign done       = r_done;

endmodule
`default_nettype wire
